// File: rtl/rotation_controller.sv
// Turns a 5-bit encoder heading toward a latched target, waits for it to settle,
// and trips a fault if the encoder stops ticking while the motor is driven.
module rotation_controller #(
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] target,
    input  logic       enc_tick,
    input  logic       abort,
    output logic       mot_cw,
    output logic       mot_ccw,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [4:0] heading
);

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        ROT_CW,
        ROT_CCW,
        SETTLE,
        DONE,
        FAULT
    } state_t;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;
    localparam logic [7:0]  SETTLE_LIM  = 8'(SETTLE_CYC);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);

    state_t      state_q, state_d;
    logic [4:0]  heading_q, heading_d;
    logic [4:0]  tgt_q, tgt_d;
    logic        dir_q, dir_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;

    logic cmp_l, cmp_e, cmp_g;

    assign cmp_l = heading_q < tgt_q;
    assign cmp_e = heading_q == tgt_q;
    assign cmp_g = heading_q > tgt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            heading_q    <= 5'd0;
            tgt_q        <= 5'd0;
            dir_q        <= DIR_CW;
            settle_cnt_q <= 8'd0;
            wd_cnt_q     <= 16'd0;
        end else begin
            state_q      <= state_d;
            heading_q    <= heading_d;
            tgt_q        <= tgt_d;
            dir_q        <= dir_d;
            settle_cnt_q <= settle_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        heading_d    = heading_q;
        tgt_d        = tgt_q;
        dir_d        = dir_q;
        settle_cnt_d = settle_cnt_q;
        wd_cnt_d     = wd_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tgt_d   = target;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (cmp_l) begin
                    state_d  = ROT_CW;
                    dir_d    = DIR_CW;
                    wd_cnt_d = 16'd0;
                end else if (cmp_g) begin
                    state_d  = ROT_CCW;
                    dir_d    = DIR_CCW;
                    wd_cnt_d = 16'd0;
                end else begin
                    state_d      = SETTLE;
                    dir_d        = DIR_CW;
                    settle_cnt_d = 8'd0;
                end
            end
            ROT_CW, ROT_CCW: begin
                if (enc_tick) begin
                    heading_d = (state_q == ROT_CW) ? heading_q + 5'd1 : heading_q - 5'd1;
                    wd_cnt_d  = 16'd0;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
                // Arrival wins over the watchdog: reaching target is never a fault.
                if (cmp_e) begin
                    state_d      = SETTLE;
                    settle_cnt_d = 8'd0;
                end else if (!enc_tick && (wd_cnt_d == TIMEOUT_LIM)) begin
                    state_d = FAULT;
                end
            end
            SETTLE: begin
                if (enc_tick) begin
                    heading_d = (dir_q == DIR_CW) ? heading_q + 5'd1 : heading_q - 5'd1;
                    state_d   = EVAL;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                    if (settle_cnt_d == SETTLE_LIM) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a tick arriving in the same cycle.
        if (abort) begin
            state_d   = IDLE;
            heading_d = heading_q;
        end
    end

    assign mot_cw  = state_q == ROT_CW;
    assign mot_ccw = state_q == ROT_CCW;
    assign busy    = (state_q != IDLE) && (state_q != FAULT);
    assign done    = state_q == DONE;
    assign fault   = state_q == FAULT;
    assign heading = heading_q;

endmodule

// File: tb/tb_rotation_controller.sv
// Directed bench for rotation_controller with SETTLE_CYC=4 and TIMEOUT_CYC=16.
module tb_rotation_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] target;
    logic       enc_tick;
    logic       abort;
    logic       mot_cw;
    logic       mot_ccw;
    logic       busy;
    logic       done;
    logic       fault;
    logic [4:0] heading;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;
    bit cw_seen = 0;
    bit ccw_seen = 0;
    bit done_seen = 0;

    rotation_controller #(
        .SETTLE_CYC (4),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .target  (target),
        .enc_tick(enc_tick),
        .abort   (abort),
        .mot_cw  (mot_cw),
        .mot_ccw (mot_ccw),
        .busy    (busy),
        .done    (done),
        .fault   (fault),
        .heading (heading)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk(tag, done, 1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mot_cw) cw_seen = 1;
            if (mot_ccw) ccw_seen = 1;
            if (done) done_seen = 1;
            chk("mot_exclusive", mot_cw & mot_ccw, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        rst = 1; start = 0; target = 0; enc_tick = 0; abort = 0;
        step(); step();
        chk("rst_heading", heading, 0);
        chk("rst_mot_cw", mot_cw, 0);
        chk("rst_mot_ccw", mot_ccw, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        rst = 0;
        mon_en = 1;
        step();
        chk("idle_busy", busy, 0);

        // Turn 0 -> 3 clockwise
        start = 1; target = 3;
        step();
        chk("s1_eval_busy", busy, 1);
        chk("s1_eval_mot", mot_cw, 0);
        start = 0; target = 0;
        step();
        chk("s1_rot_cw", mot_cw, 1);
        enc_tick = 1;
        step(); chk("s1_hd1", heading, 1);
        step(); chk("s1_hd2", heading, 2);
        step(); chk("s1_hd3", heading, 3);
        chk("s1_mot_on_at_tgt", mot_cw, 1);
        enc_tick = 0;
        step();
        chk("s1_mot_off", mot_cw, 0);
        chk("s1_settle_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s1_settle_nodone", done, 0);
        end
        step();
        chk("s1_done", done, 1);
        chk("s1_heading", heading, 3);
        step();
        chk("s1_done_pulse", done, 0);
        chk("s1_idle", busy, 0);

        // Overshoot during a settle entered straight from EVAL
        start = 1; target = 3;
        step();
        start = 0;
        step();
        chk("s4_settle_nomot", mot_cw | mot_ccw, 0);
        chk("s4_settle_busy", busy, 1);
        enc_tick = 1;
        step();
        chk("s4_overshoot", heading, 4);
        enc_tick = 0;
        step();
        chk("s4_rot_ccw", mot_ccw, 1);
        enc_tick = 1;
        step();
        chk("s4_back", heading, 3);
        enc_tick = 0;
        step();
        chk("s4_mot_off", mot_ccw, 0);
        wait_done("s4_done");
        chk("s4_heading", heading, 3);

        // Turn 3 -> 0 counter-clockwise
        cw_seen = 0;
        step();
        start = 1; target = 0;
        step();
        start = 0;
        step();
        chk("s2_rot_ccw", mot_ccw, 1);
        enc_tick = 1;
        step(); chk("s2_hd2", heading, 2);
        step(); chk("s2_hd1", heading, 1);
        step(); chk("s2_hd0", heading, 0);
        enc_tick = 0;
        wait_done("s2_done");
        chk("s2_no_cw", cw_seen, 0);

        // Move to 5 for the equal-target case
        step();
        start = 1; target = 5;
        step();
        start = 0;
        step();
        enc_tick = 1;
        repeat (5) step();
        enc_tick = 0;
        wait_done("prep_done");
        chk("prep_heading", heading, 5);

        // Target equal to heading
        step();
        cw_seen = 0; ccw_seen = 0;
        start = 1; target = 5;
        step();
        start = 0;
        step();
        chk("s3_settle_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s3_nodone", done, 0);
        end
        step();
        chk("s3_done", done, 1);
        chk("s3_no_cw", cw_seen, 0);
        chk("s3_no_ccw", ccw_seen, 0);

        // Watchdog timeout
        step();
        start = 1; target = 10;
        step();
        start = 0;
        step();
        n = 0;
        while (mot_cw && n < 40) begin
            step();
            n++;
        end
        chk("s5_rot_cycles", n, 16);
        chk("s5_fault", fault, 1);
        chk("s5_mot_off", mot_cw | mot_ccw, 0);
        chk("s5_busy", busy, 0);
        start = 1; target = 7; enc_tick = 1;
        step();
        chk("s5_fault_hold", fault, 1);
        chk("s5_tick_ignored", heading, 5);
        start = 0; enc_tick = 0; abort = 1;
        step();
        chk("s5_abort_fault", fault, 0);
        chk("s5_abort_busy", busy, 0);
        abort = 0;
        step();
        chk("s5_idle_stays", busy, 0);

        // Abort mid-rotation, with a tick in the abort cycle
        done_seen = 0;
        start = 1; target = 9;
        step();
        start = 0;
        step();
        chk("s6_rot_cw", mot_cw, 1);
        enc_tick = 1;
        step();
        chk("s6_hd6", heading, 6);
        abort = 1;
        step();
        chk("s6_mot_off", mot_cw, 0);
        chk("s6_busy", busy, 0);
        chk("s6_heading", heading, 6);
        abort = 0; enc_tick = 0;
        repeat (6) step();
        chk("s6_no_done", done_seen, 0);

        // Reset mid-rotation, beating a simultaneous abort
        start = 1; target = 9;
        step();
        start = 0;
        step();
        enc_tick = 1;
        step();
        enc_tick = 0;
        chk("s7_hd7", heading, 7);
        rst = 1; abort = 1;
        step();
        chk("s7_heading", heading, 0);
        chk("s7_mot_off", mot_cw, 0);
        chk("s7_busy", busy, 0);
        rst = 0; abort = 0;
        repeat (6) step();
        chk("s7_no_done", done_seen, 0);

        // Tick coinciding with arrival, then wrap below zero
        start = 1; target = 2;
        step();
        start = 0;
        step();
        enc_tick = 1;
        step();
        step();
        chk("s8_at_tgt_mot", mot_cw, 1);
        step();
        enc_tick = 0;
        chk("s8_tick_and_eq", heading, 3);
        chk("s8_settle_mot", mot_cw, 0);
        chk("s8_settle_busy", busy, 1);
        wait_done("s8_done_cw");
        step();
        start = 1; target = 0;
        step();
        start = 0;
        step();
        chk("s8_rot_ccw", mot_ccw, 1);
        enc_tick = 1;
        repeat (4) step();
        enc_tick = 0;
        chk("s8_wrap", heading, 31);
        chk("s8_wrap_mot_off", mot_ccw, 0);
        wait_done("s8_done_ccw");
        chk("s8_final_heading", heading, 31);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotation_controller.md
ROTATION_CONTROLLER -- requirements
Module: rotation_controller

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 8: consecutive cycles the heading must hold at target before completion (range 1..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 1024: maximum cycles allowed between encoder ticks while rotating (range 1..65535).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request a turn to target; sampled in IDLE only.
REQ-006 The block SHALL have port target  input  5  desired heading in encoder steps; latched on accepted start.
REQ-007 The block SHALL have port enc_tick  input  1  one-cycle pulse per encoder step.
REQ-008 The block SHALL have port abort  input  1  cancel any operation.
REQ-009 The block SHALL have port mot_cw  output  1  drive motor clockwise (heading increasing).
REQ-010 The block SHALL have port mot_ccw  output  1  drive motor counter-clockwise (heading decreasing).
REQ-011 The block SHALL have port busy  output  1  high in every state except IDLE and FAULT.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-013 The block SHALL have port fault  output  1  high while in FAULT.
REQ-014 The block SHALL have port heading  output  5  current heading register.

Function
REQ-015 The block SHALL implement FSM states IDLE, EVAL, ROT_CW, ROT_CCW, SETTLE, DONE and FAULT.
REQ-016 The block SHALL make all outputs registered or decoded from state and registers, with no combinational path from any input to any output.
REQ-017 IDLE: start=1 SHALL latch target into tgt_q and go to EVAL next cycle; start SHALL be ignored in all other states.
REQ-018 The block SHALL compute the 5-bit unsigned compare heading vs tgt_q each cycle as L (heading<tgt_q), E (equal) and G (heading>tgt_q).
REQ-019 EVAL SHALL go to ROT_CW if L, ROT_CCW if G, and SETTLE if E; the block SHALL take no shortest-path or wrap-around decision.
REQ-020 mot_cw SHALL be 1 only in ROT_CW, mot_ccw SHALL be 1 only in ROT_CCW, and the two SHALL never be 1 together.
REQ-021 ROT_CW: enc_tick SHALL increment heading by 1; ROT_CCW: enc_tick SHALL decrement heading by 1.
REQ-022 Heading arithmetic SHALL be modulo 32, so 31+1 gives 0 and 0-1 gives 31.
REQ-023 In a ROT state with E true, the FSM SHALL go to SETTLE next cycle, so the motor stays on exactly 1 cycle after heading reaches tgt_q.
REQ-024 The block SHALL record the last rotation direction (cw/ccw) in dir_q on entering each ROT state.
REQ-025 SETTLE: the settle counter SHALL clear on entry and increment each cycle; on reaching SETTLE_CYC the FSM SHALL go to DONE.
REQ-026 SETTLE: enc_tick (coast/overshoot) SHALL update heading by ±1 per dir_q and go to EVAL next cycle.
REQ-027 A SETTLE entered directly from EVAL SHALL have dir_q=cw and SHALL treat a tick as cw.
REQ-028 DONE SHALL assert done for one cycle and then go to IDLE.
REQ-029 The watchdog counter (16 bit) SHALL clear on ROT-state entry and on every enc_tick, and SHALL increment otherwise in ROT states.
REQ-030 When the watchdog counter reaches TIMEOUT_CYC, the FSM SHALL go to FAULT and motors SHALL be off next cycle.
REQ-031 FAULT SHALL hold fault=1 and SHALL ignore start and enc_tick; only abort or rst SHALL exit FAULT, and both exit to IDLE.
REQ-032 abort=1 in any state SHALL force IDLE next cycle with motors off and no done pulse, and abort SHALL take priority over start, enc_tick, timeout and settle completion.
REQ-033 enc_tick SHALL be ignored in IDLE, EVAL, DONE and FAULT, and heading SHALL be unchanged in those states.
REQ-034 If a tick and E occur in the same ROT cycle, the heading update SHALL take effect and the FSM SHALL still go to SETTLE.

Reset
REQ-035 rst=1 at a rising edge SHALL set state=IDLE, heading=0, tgt_q=0, dir_q=cw, all counters=0, and mot_cw, mot_ccw, busy, done and fault=0.
REQ-036 rst SHALL take priority over abort and all other inputs, including mid-rotation, with motors off the cycle after reset is sampled.

Verification (SETTLE_CYC=4, TIMEOUT_CYC=16)
REQ-037 The bench SHALL cover: after reset, start with target=3 -> EVAL, ROT_CW; 3 ticks give heading 1,2,3; mot_cw drops 1 cycle after heading=3; SETTLE 4 cycles; done pulse; heading=3.
REQ-038 The bench SHALL cover: from heading=3, start with target=0 -> mot_ccw; 3 ticks give heading 0; done; mot_cw never asserted.
REQ-039 The bench SHALL cover: start with target=heading=5 -> EVAL, SETTLE, done after 4 cycles with no motor output.
REQ-040 The bench SHALL cover: tick during SETTLE at heading=3 with dir_q=cw -> heading=4, EVAL, ROT_CCW, one tick gives 3, then done.
REQ-041 The bench SHALL cover: in ROT_CW with no ticks for 16 cycles -> FAULT with fault=1 and motors off; start ignored; abort returns to IDLE with fault=0.
REQ-042 The bench SHALL cover: abort or rst asserted mid-ROT_CW -> IDLE next cycle, motors 0, done never pulses; rst additionally clears heading to 0.
